// File: rtl/riscv_hwloop_pkg.sv
// Shared types and constants for the hardware-loop controller.
package riscv_hwloop_pkg;

    localparam int HWLP_ADDR_W = 32;

    typedef enum logic {
        IDLE      = 1'b0,
        JUMP_PEND = 1'b1
    } hwlp_state_e;

endpackage

// File: rtl/riscv_hwloop_match.sv
// Combinational loop-end detection: per-loop PC compare, active check and a
// lowest-index priority encoder, so the innermost matching loop wins.
module riscv_hwloop_match
    import riscv_hwloop_pkg::*;
#(
    parameter int N_REGS     = 2,
    parameter int N_REG_BITS = $clog2(N_REGS)
) (
    input  logic [HWLP_ADDR_W-1:0] current_pc_i,
    input  logic                   pc_valid_i,
    input  logic [HWLP_ADDR_W-1:0] hwlp_end_addr_i [N_REGS],
    input  logic [HWLP_ADDR_W-1:0] hwlp_counter_i  [N_REGS],
    output logic                   match_o,
    output logic [N_REG_BITS-1:0]  index_o,
    output logic                   jump_needed_o
);

    // Scan from the outermost loop down so the lowest matching index is the last write.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        match_o       = 1'b0;
        index_o       = '0;
        jump_needed_o = 1'b0;
        for (int k = N_REGS - 1; k >= 0; k--) begin
            if (pc_valid_i && (current_pc_i == hwlp_end_addr_i[k]) &&
                (hwlp_counter_i[k] != '0)) begin
                match_o       = 1'b1;
                index_o       = N_REG_BITS'(k);
                // Pre-decrement count: 1 means this is the last pass, so fall through.
                jump_needed_o = (hwlp_counter_i[k] > 32'd1);
            end
        end
    end

endmodule

// File: rtl/riscv_hwloop_ctrl_seq.sv
// Hardware-loop controller: issues decrement pulses to the loop register file
// and a registered, handshaked jump request back to the loop start address.
module riscv_hwloop_ctrl_seq
    import riscv_hwloop_pkg::*;
#(
    parameter int N_REGS     = 2,
    parameter int N_REG_BITS = $clog2(N_REGS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [HWLP_ADDR_W-1:0] current_pc_i,
    input  logic                   pc_valid_i,
    input  logic                   id_ready_i,
    input  logic                   if_ready_i,
    input  logic                   flush_i,
    input  logic [HWLP_ADDR_W-1:0] hwlp_start_addr_i [N_REGS],
    input  logic [HWLP_ADDR_W-1:0] hwlp_end_addr_i   [N_REGS],
    input  logic [HWLP_ADDR_W-1:0] hwlp_counter_i    [N_REGS],
    output logic [N_REGS-1:0]      hwlp_dec_cnt_o,
    output logic                   hwlp_jump_o,
    output logic [HWLP_ADDR_W-1:0] hwlp_targ_addr_o,
    output logic                   hwlp_busy_o,
    output logic [N_REG_BITS-1:0]  hwlp_loop_id_o
);

    hwlp_state_e             state_q, state_d;
    logic [HWLP_ADDR_W-1:0]  targ_q;
    logic [N_REG_BITS-1:0]   loop_id_q;
    logic                    match;
    logic [N_REG_BITS-1:0]   match_idx;
    logic                    jump_needed;
    logic                    take;

    riscv_hwloop_match #(
        .N_REGS     (N_REGS),
        .N_REG_BITS (N_REG_BITS)
    ) u_match (
        .current_pc_i    (current_pc_i),
        .pc_valid_i      (pc_valid_i),
        .hwlp_end_addr_i (hwlp_end_addr_i),
        .hwlp_counter_i  (hwlp_counter_i),
        .match_o         (match),
        .index_o         (match_idx),
        .jump_needed_o   (jump_needed)
    );

    // Only a retiring, unflushed loop-end instruction in IDLE is acted on; a stall never re-triggers.
    assign take = (state_q == IDLE) && match && id_ready_i && !flush_i;

    // Next-state logic and the one-hot decrement pulse for the selected loop.
    always_comb begin
        state_d        = state_q;
        hwlp_dec_cnt_o = '0;
        unique case (state_q)
            IDLE: begin
                if (take) begin
                    hwlp_dec_cnt_o[match_idx] = 1'b1;
                    if (jump_needed) state_d = JUMP_PEND;
                end
            end
            JUMP_PEND: begin
                // Flush drops the jump; the decrement already issued stands.
                if (flush_i || if_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register plus jump target/owner, captured once when the jump is decided.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            targ_q    <= '0;
            loop_id_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            if (take && jump_needed) begin
                targ_q    <= hwlp_start_addr_i[match_idx];
                loop_id_q <= match_idx;
            end
        end
    end

    assign hwlp_jump_o      = (state_q == JUMP_PEND);
    assign hwlp_busy_o      = (state_q == JUMP_PEND);
    assign hwlp_targ_addr_o = targ_q;
    assign hwlp_loop_id_o   = loop_id_q;

endmodule

// File: tb/tb_riscv_hwloop_ctrl_seq.sv
// Directed self-checking bench for riscv_hwloop_ctrl_seq. The bench plays the
// role of the loop register file, updating counters by hand between vectors.
module tb_riscv_hwloop_ctrl_seq;

    logic        clk;
    logic        rst_n;
    logic [31:0] current_pc;
    logic        pc_valid;
    logic        id_ready;
    logic        if_ready;
    logic        flush;
    logic [31:0] start_addr [2];
    logic [31:0] end_addr   [2];
    logic [31:0] counter    [2];
    logic [1:0]  dec_cnt;
    logic        jump;
    logic [31:0] targ_addr;
    logic        busy;
    logic [0:0]  loop_id;

    int n_vec = 0;
    int n_err = 0;

    riscv_hwloop_ctrl_seq #(.N_REGS(2)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .current_pc_i      (current_pc),
        .pc_valid_i        (pc_valid),
        .id_ready_i        (id_ready),
        .if_ready_i        (if_ready),
        .flush_i           (flush),
        .hwlp_start_addr_i (start_addr),
        .hwlp_end_addr_i   (end_addr),
        .hwlp_counter_i    (counter),
        .hwlp_dec_cnt_o    (dec_cnt),
        .hwlp_jump_o       (jump),
        .hwlp_targ_addr_o  (targ_addr),
        .hwlp_busy_o       (busy),
        .hwlp_loop_id_o    (loop_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_pend(input string tag, input logic [31:0] exp_targ, input logic exp_id);
        check({tag, ".jump"}, {31'd0, jump}, 32'd1);
        check({tag, ".busy"}, {31'd0, busy}, 32'd1);
        check({tag, ".targ"}, targ_addr, exp_targ);
        check({tag, ".loop_id"}, {31'd0, loop_id}, {31'd0, exp_id});
        check({tag, ".dec"}, {30'd0, dec_cnt}, 32'd0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".jump"}, {31'd0, jump}, 32'd0);
        check({tag, ".busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        current_pc = 32'h0;
        pc_valid   = 1'b0;
        id_ready   = 1'b0;
        if_ready   = 1'b0;
        flush      = 1'b0;
        start_addr = '{32'h100, 32'h0};
        end_addr   = '{32'h10C, 32'h0};
        counter    = '{32'd0, 32'd0};
        #1;
        check("reset.jump", {31'd0, jump}, 32'd0);
        check("reset.targ", targ_addr, 32'd0);
        check("reset.busy", {31'd0, busy}, 32'd0);
        check("reset.loop_id", {31'd0, loop_id}, 32'd0);
        check("reset.dec", {30'd0, dec_cnt}, 32'd0);
        #11 rst_n = 1'b1;
        step();

        // ---- Loop 0: 3 iterations, jump twice, fall through on last ----
        current_pc = 32'h10C; pc_valid = 1'b1; if_ready = 1'b1;
        counter[0] = 32'd3;   id_ready = 1'b1;
        #1 check("it3.dec", {30'd0, dec_cnt}, 32'd1);
        step(); id_ready = 1'b0; counter[0] = 32'd2;
        check_pend("it3", 32'h100, 1'b0);
        step(); check_idle("it3.accept");

        id_ready = 1'b1;
        #1 check("it2.dec", {30'd0, dec_cnt}, 32'd1);
        step(); id_ready = 1'b0; counter[0] = 32'd1;
        check_pend("it2", 32'h100, 1'b0);
        step(); check_idle("it2.accept");

        id_ready = 1'b1;
        #1 check("it1.dec", {30'd0, dec_cnt}, 32'd1);
        step(); counter[0] = 32'd0;
        check_idle("it1.nojump");
        #1 check("done.dec", {30'd0, dec_cnt}, 32'd0);
        step(); check_idle("done");

        // ---- pc_valid low suppresses a match ----
        counter[0] = 32'd3; pc_valid = 1'b0;
        #1 check("novalid.dec", {30'd0, dec_cnt}, 32'd0);
        step(); check_idle("novalid");
        pc_valid = 1'b1;

        // ---- Stall for 4 cycles, then a single decrement ----
        id_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("stall.dec", {30'd0, dec_cnt}, 32'd0);
            step();
            check_idle("stall");
        end
        id_ready = 1'b1; if_ready = 1'b0;
        #1 check("stall.release.dec", {30'd0, dec_cnt}, 32'd1);

        // ---- Fetch backpressure for 3 cycles ----
        step(); id_ready = 1'b0; counter[0] = 32'd2;
        for (int i = 0; i < 3; i++) begin
            check_pend("bp", 32'h100, 1'b0);
            if (i < 2) step();
        end
        if_ready = 1'b1;
        #1 check_pend("bp.accept", 32'h100, 1'b0);
        step(); check_idle("bp.done");

        // ---- Nested loops sharing end address 0x200 ----
        start_addr = '{32'h1E0, 32'h1F0};
        end_addr   = '{32'h200, 32'h200};
        counter    = '{32'd1,   32'd5};
        current_pc = 32'h200; id_ready = 1'b1;
        #1 check("nest.inner.dec", {30'd0, dec_cnt}, 32'd1);
        step(); counter[0] = 32'd0;
        check_idle("nest.inner");
        #1 check("nest.outer.dec", {30'd0, dec_cnt}, 32'd2);
        step(); id_ready = 1'b0; counter[1] = 32'd4;
        check_pend("nest.outer", 32'h1F0, 1'b1);
        step(); check_idle("nest.accept");

        // ---- Flush with if_ready in JUMP_PEND, then flush in IDLE ----
        start_addr = '{32'h100, 32'h0};
        end_addr   = '{32'h10C, 32'h0};
        counter    = '{32'd3,   32'd0};
        current_pc = 32'h10C; id_ready = 1'b1; if_ready = 1'b0;
        #1 check("fl.dec", {30'd0, dec_cnt}, 32'd1);
        step(); id_ready = 1'b0; counter[0] = 32'd2;
        check_pend("fl", 32'h100, 1'b0);
        flush = 1'b1; if_ready = 1'b1;
        step(); check_idle("fl.drop");
        id_ready = 1'b1;
        #1 check("fl.idle.dec", {30'd0, dec_cnt}, 32'd0);
        step(); check_idle("fl.idle");
        flush = 1'b0;

        // ---- Asynchronous reset while a jump is pending ----
        if_ready = 1'b0;
        #1 check("rst.take.dec", {30'd0, dec_cnt}, 32'd1);
        step(); id_ready = 1'b0;
        check_pend("rst.pend", 32'h100, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("rst.async.jump", {31'd0, jump}, 32'd0);
        check("rst.async.targ", targ_addr, 32'd0);
        check("rst.async.busy", {31'd0, busy}, 32'd0);
        check("rst.async.loop_id", {31'd0, loop_id}, 32'd0);
        check("rst.async.dec", {30'd0, dec_cnt}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
